// File: rtl/line_read_buffer_pkg.sv
// Shared types and constants for the line read buffer and its lane selector.
//   LINE_W     : default stored line width in bits
//   LANE_W     : default output lane width in bits
//   lane_idx_t : 8-bit lane index (start, end and current lane)
//   state_e    : drain state machine encoding (idle / drain)
package line_read_buffer_pkg;

  localparam int unsigned LINE_W = 512;
  localparam int unsigned LANE_W = 64;

  typedef logic [7:0] lane_idx_t;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StDrain = 1'b1
  } state_e;

endpackage

// File: rtl/line_read_buffer_if.sv
// Bundle of the load/stream signals of line_read_buffer.
//   rready/rdata/base/bounds : line load from the read-data channel
//   odata_req                : consumer can take a lane this cycle
//   oready/odata             : emitted lane, valid for exactly one cycle
//   busy                     : line loaded and not yet drained
//   ovf                      : sticky dropped-load flag (LINE_READ_BUFFER_OVF_EN only)
// Modports: slave = the buffer, master = producer/consumer side.
interface line_read_buffer_if #(
  parameter int unsigned FULL_WIDTH = line_read_buffer_pkg::LINE_W,
  parameter int unsigned WIDTH      = line_read_buffer_pkg::LANE_W
);
  import line_read_buffer_pkg::*;

  logic                  rready;
  logic [FULL_WIDTH-1:0] rdata;
  logic                  odata_req;
  lane_idx_t             base;
  lane_idx_t             bounds;
  logic                  oready;
  logic [WIDTH-1:0]      odata;
  logic                  busy;
`ifdef LINE_READ_BUFFER_OVF_EN
  logic                  ovf;
`endif

  modport slave (
    input  rready, rdata, odata_req, base, bounds,
`ifdef LINE_READ_BUFFER_OVF_EN
    output ovf,
`endif
    output oready, odata, busy
  );

  modport master (
    output rready, rdata, odata_req, base, bounds,
`ifdef LINE_READ_BUFFER_OVF_EN
    input  ovf,
`endif
    input  oready, odata, busy
  );

endinterface

// File: rtl/line_lane_select.sv
// Combinational lane picker: returns lane idx_i of line_i, lane 0 being the
// most significant WIDTH-bit slice. Indices at or beyond the lane count give 0.
//   line_i : FULL_WIDTH-bit line
//   idx_i  : lane index
//   lane_o : selected WIDTH-bit lane
module line_lane_select import line_read_buffer_pkg::*; #(
  parameter int unsigned FULL_WIDTH = LINE_W,
  parameter int unsigned WIDTH      = LANE_W
) (
  input  logic [FULL_WIDTH-1:0] line_i,
  input  lane_idx_t             idx_i,
  output logic [WIDTH-1:0]      lane_o
);

  localparam int unsigned N = FULL_WIDTH / WIDTH;

  always_comb begin
    lane_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_i == lane_idx_t'(i)) begin
        lane_o = line_i[FULL_WIDTH-1-i*WIDTH -: WIDTH];
      end
    end
  end

endmodule

// File: rtl/line_read_buffer.sv
// Holds one memory read line and streams lanes [base, min(bounds, N)) out,
// one lane per requested cycle, with one cycle of latency from odata_req to
// oready. Loads arriving while busy are dropped.
//   clk, rst : clock, synchronous active-high reset
//   lrb      : line_read_buffer_if.slave (load, stream and status signals)
// Optional build macro LINE_READ_BUFFER_OVF_EN adds the sticky lrb.ovf flag,
// set by a load that arrives while busy and cleared only by rst.
module line_read_buffer import line_read_buffer_pkg::*; #(
  parameter int unsigned FULL_WIDTH = LINE_W,
  parameter int unsigned WIDTH      = LANE_W
) (
  input logic               clk,
  input logic               rst,
  line_read_buffer_if.slave lrb
);

  localparam int unsigned N        = FULL_WIDTH / WIDTH;
  localparam lane_idx_t   NumLanes = lane_idx_t'(N);

  localparam logic [0:0] ST_IDLE  = StIdle;
  localparam logic [0:0] ST_DRAIN = StDrain;

  if ((FULL_WIDTH % WIDTH) != 0 || N > 255 || N == 0) begin : g_bad_cfg
    $error("line_read_buffer: FULL_WIDTH must be 1..255 multiples of WIDTH");
  end

  logic [0:0]            state_q, state_d;
  logic [FULL_WIDTH-1:0] line_q, line_d;
  lane_idx_t             idx_q, idx_d;
  lane_idx_t             end_q, end_d;
  logic                  oready_q, oready_d;
  logic [WIDTH-1:0]      odata_q, odata_d;

  lane_idx_t             end_eff;
  lane_idx_t             idx_inc;
  logic [WIDTH-1:0]      lane_sel;
  logic                  busy;

  line_lane_select #(
    .FULL_WIDTH (FULL_WIDTH),
    .WIDTH      (WIDTH)
  ) u_lane_select (
    .line_i (line_q),
    .idx_i  (idx_q),
    .lane_o (lane_sel)
  );

  assign busy    = (state_q == ST_DRAIN);
  assign idx_inc = idx_q + 8'd1;

  always_comb begin
    end_eff  = (lrb.bounds > NumLanes) ? NumLanes : lrb.bounds;
    state_d  = state_q;
    line_d   = line_q;
    idx_d    = idx_q;
    end_d    = end_q;
    odata_d  = odata_q;
    // oready is a one-cycle pulse per emitted lane
    oready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // empty ranges (incl. base >= N or bounds == 0) are silently ignored
        if (lrb.rready && (lrb.base < end_eff)) begin
          line_d  = lrb.rdata;
          idx_d   = lrb.base;
          end_d   = end_eff;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (lrb.odata_req) begin
          odata_d  = lane_sel;
          oready_d = 1'b1;
          idx_d    = idx_inc;
          if (idx_inc == end_q) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      idx_q    <= '0;
      end_q    <= '0;
      oready_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      idx_q    <= idx_d;
      end_q    <= end_d;
      oready_q <= oready_d;
      odata_q  <= odata_d;
    end
  end

  assign lrb.oready = oready_q;
  assign lrb.odata  = odata_q;
  assign lrb.busy   = busy;

`ifdef LINE_READ_BUFFER_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (lrb.rready & busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign lrb.ovf = ovf_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && lrb.rready && busy) begin
      $display("line_read_buffer: dropped load base=%0d bounds=%0d", lrb.base, lrb.bounds);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_line_read_buffer.sv
// Self-checking bench for line_read_buffer: table of load ranges, hand-written
// back-pressure / load-while-busy / reset-mid-drain sequences, and random
// traffic, all checked against a queue-based model of the lane stream.
module tb_line_read_buffer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_read_buffer_if #(.FULL_WIDTH(512), .WIDTH(64)) lrb ();

  line_read_buffer #(
    .FULL_WIDTH (512),
    .WIDTH      (64)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .lrb (lrb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: pending lanes of the current line; empty means not busy
  logic [63:0] q_m[$];
  logic        oready_m;
  logic [63:0] odata_m;
  logic        ovf_m;

  // observed emissions for the hand-written checks
  logic [63:0] emits[$];
  int          emit_cyc[$];
  int          cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lane_of(input logic [511:0] l, input int i);
    return l[511-i*64 -: 64];
  endfunction

  function automatic logic [511:0] mk_line(input logic [63:0] first);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[511-i*64 -: 64] = first + 64'(i);
    return l;
  endfunction

  task automatic step(input logic rr, input logic [511:0] rd, input logic [7:0] b,
                      input logic [7:0] bd, input logic req, input logic r);
    logic busy_before;
    int   e;
    lrb.rready    = rr;
    lrb.rdata     = rd;
    lrb.base      = b;
    lrb.bounds    = bd;
    lrb.odata_req = req;
    rst           = r;
    @(posedge clk);
    cyc++;
    busy_before = (q_m.size() != 0);
    if (r) begin
      q_m.delete();
      oready_m = 1'b0;
      odata_m  = '0;
      ovf_m    = 1'b0;
    end else begin
      if (rr && busy_before) ovf_m = 1'b1;
      if (busy_before) begin
        oready_m = 1'b0;
        if (req) begin
          odata_m  = q_m.pop_front();
          oready_m = 1'b1;
        end
      end else begin
        oready_m = 1'b0;
        if (rr) begin
          e = (int'(bd) > 8) ? 8 : int'(bd);
          for (int i = int'(b); i < e; i++) q_m.push_back(lane_of(rd, i));
        end
      end
    end
    #1;
    chk("oready", 64'(lrb.oready), 64'(oready_m));
    chk("busy", 64'(lrb.busy), 64'(q_m.size() != 0));
    chk("odata", lrb.odata, odata_m);
`ifdef LINE_READ_BUFFER_OVF_EN
    chk("ovf", 64'(lrb.ovf), 64'(ovf_m));
`endif
    if (lrb.oready === 1'b1) begin
      emits.push_back(lrb.odata);
      emit_cyc.push_back(cyc);
    end
  endtask

  task automatic idle_n(input int n, input logic req);
    for (int i = 0; i < n; i++) step(1'b0, '0, 8'd0, 8'd0, req, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  bounds;
    int          count;
    logic [63:0] first;
    logic [63:0] last;
  } vec_t;

  vec_t vecs[9];

  logic [511:0] line_a, line_b, rl;
  int           load_cyc;

  initial begin
    vecs[0] = '{8'd0, 8'd8,   8, 64'h10, 64'h17};
    vecs[1] = '{8'd3, 8'd6,   3, 64'h13, 64'h15};
    vecs[2] = '{8'd6, 8'd12,  2, 64'h16, 64'h17};
    vecs[3] = '{8'd5, 8'd5,   0, 64'h0,  64'h0};
    vecs[4] = '{8'd0, 8'd0,   0, 64'h0,  64'h0};
    vecs[5] = '{8'd9, 8'd12,  0, 64'h0,  64'h0};
    vecs[6] = '{8'd7, 8'd255, 1, 64'h17, 64'h17};
    vecs[7] = '{8'd0, 8'd1,   1, 64'h10, 64'h10};
    vecs[8] = '{8'd2, 8'd3,   1, 64'h12, 64'h12};

    line_a   = mk_line(64'h10);
    line_b   = mk_line(64'h80);
    cyc      = 0;
    oready_m = 1'b0;
    odata_m  = '0;
    ovf_m    = 1'b0;

    // reset state
    step(1'b0, '0, 8'd0, 8'd0, 1'b0, 1'b1);
    step(1'b1, line_a, 8'd0, 8'd8, 1'b1, 1'b1);
    chk("rst_oready", 64'(lrb.oready), 64'h0);
    chk("rst_busy", 64'(lrb.busy), 64'h0);
    chk("rst_odata", lrb.odata, 64'h0);

    // table: ranges with odata_req held high
    foreach (vecs[k]) begin
      emits.delete();
      emit_cyc.delete();
      step(1'b1, line_a, vecs[k].base, vecs[k].bounds, 1'b1, 1'b0);
      load_cyc = cyc;
      idle_n(10, 1'b1);
      chk($sformatf("vec%0d_count", k), 64'(emits.size()), 64'(vecs[k].count));
      if (vecs[k].count > 0 && emits.size() > 0) begin
        chk($sformatf("vec%0d_first", k), emits[0], vecs[k].first);
        chk($sformatf("vec%0d_last", k), emits[emits.size()-1], vecs[k].last);
        chk($sformatf("vec%0d_lat", k), 64'(emit_cyc[0] - load_cyc), 64'd1);
        chk($sformatf("vec%0d_span", k), 64'(emit_cyc[emits.size()-1] - emit_cyc[0]),
            64'(vecs[k].count - 1));
      end
    end

    // back-pressure: req pattern 1,0,0,1,1 repeating
    emits.delete();
    step(1'b1, line_a, 8'd0, 8'd8, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      step(1'b0, '0, 8'd0, 8'd0, (i % 5 == 0) || (i % 5 >= 3), 1'b0);
    end
    chk("bp_count", 64'(emits.size()), 64'd8);
    for (int i = 0; i < emits.size() && i < 8; i++) chk("bp_order", emits[i], 64'h10 + 64'(i));

    // load while busy: second line must never appear
    emits.delete();
    step(1'b1, line_a, 8'd0, 8'd8, 1'b1, 1'b0);
    idle_n(3, 1'b1);
    step(1'b1, line_b, 8'd0, 8'd8, 1'b1, 1'b0);
    idle_n(3, 1'b1);
    step(1'b1, line_b, 8'd0, 8'd8, 1'b1, 1'b0);  // lands on the final drain cycle
    idle_n(4, 1'b1);
    chk("lwb_count", 64'(emits.size()), 64'd8);
    for (int i = 0; i < emits.size() && i < 8; i++) chk("lwb_order", emits[i], 64'h10 + 64'(i));
`ifdef LINE_READ_BUFFER_OVF_EN
    chk("lwb_ovf_sticky", 64'(lrb.ovf), 64'd1);
`endif

    // reset mid-drain, then reload
    emits.delete();
    step(1'b1, line_a, 8'd0, 8'd8, 1'b1, 1'b0);
    idle_n(3, 1'b1);
    chk("rmd_pre", 64'(emits.size()), 64'd3);
    step(1'b1, line_b, 8'd0, 8'd8, 1'b1, 1'b1);  // reset wins over load
    chk("rmd_oready", 64'(lrb.oready), 64'd0);
    chk("rmd_busy", 64'(lrb.busy), 64'd0);
    emits.delete();
    step(1'b1, line_b, 8'd0, 8'd2, 1'b1, 1'b0);
    idle_n(4, 1'b1);
    chk("rmd_count", 64'(emits.size()), 64'd2);
    if (emits.size() == 2) begin
      chk("rmd_lane0", emits[0], 64'h80);
      chk("rmd_lane1", emits[1], 64'h81);
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 8; i++) rl[511-i*64 -: 64] = {$urandom, $urandom};
      step($urandom_range(0, 3) == 0, rl, 8'($urandom_range(0, 10)),
           8'($urandom_range(0, 12)), $urandom_range(0, 2) != 0,
           $urandom_range(0, 63) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
